// File: rtl/nand_phy_pkg.sv
// Shared types and helpers for the NAND PHY DQS sequencing controller.
package nand_phy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_PRE,
    ST_RD_BURST,
    ST_RD_POST,
    ST_WR_PRE,
    ST_WR_BURST,
    ST_WR_POST
  } ch_state_e;

  typedef enum logic [1:0] {
    TAP_NONE,
    TAP_INC,
    TAP_DEC,
    TAP_RST
  } tap_op_e;

  // Cycles during which no further tap adjustment is applied.
  localparam int unsigned LOCKOUT_CYC = 2;

  // Counter value loaded on entry to a state: its duration in cycles.
  function automatic logic [31:0] state_load(ch_state_e st, logic [31:0] len,
                                             int unsigned rd_lat, int unsigned pre,
                                             int unsigned post);
    logic [31:0] val;
    val = '0;
    case (st)
      ST_RD_WAIT:                val = rd_lat;
      ST_RD_PRE,   ST_WR_PRE:    val = pre;
      ST_RD_BURST, ST_WR_BURST:  val = len;
      ST_RD_POST,  ST_WR_POST:   val = post;
      default:                   val = '0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/nand_phy_dqs_ctrl_ch.sv
// Single DQS channel: read gate / write preamble-burst-postamble FSM plus
// IDELAY tap bookkeeping with a one-deep pending slot and lockout.
module nand_dqs_ch_ctrl
  import nand_phy_pkg::*;
#(
  parameter int unsigned TAP_W    = 5,
  parameter int unsigned BURST_W  = 8,
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned PRE_CYC  = 1,
  parameter int unsigned POST_CYC = 1
) (
  input  logic               clk0,
  input  logic               rst0_n,
  input  logic               rd_start,
  input  logic               wr_start,
  input  logic [BURST_W-1:0] burst_len,
  output logic               busy,
  output logic               done,
  output logic               start_err,
  output logic               dqs_gate,
  output logic               dqs_oe_n,
  output logic               dqs_rst_n,
  input  logic               tap_inc_req,
  input  logic               tap_dec_req,
  input  logic               tap_rst_req,
  output logic               dlyce_dqs,
  output logic               dlyinc_dqs,
  output logic               dlyrst_dqs,
  output logic [TAP_W-1:0]   tap_val,
  output logic               tap_sat
);

  localparam int unsigned LK_W = $clog2(LOCKOUT_CYC + 1);

  ch_state_e          state, state_nxt;
  logic [31:0]        cnt, cnt_nxt;
  logic [BURST_W-1:0] len_q, len_nxt;
  logic               start_rej;
  logic               last;

  tap_op_e            req_op, pend_op, pend_nxt, apply_op;
  logic [LK_W-1:0]    lock, lock_nxt;
  logic [TAP_W-1:0]   tap_nxt;
  logic               ce_nxt, inc_nxt, drst_nxt, sat_nxt;
  logic               in_window, tap_free;

  assign last = (cnt == 32'd1);

  // Next-state decode; the down-counter is reloaded on every state change.
  always_comb begin
    state_nxt = state;
    len_nxt   = len_q;
    start_rej = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (rd_start || wr_start) begin
          if (burst_len == '0) begin
            start_rej = 1'b1;
          end else begin
            len_nxt = burst_len;
            if (rd_start) state_nxt = (RD_LAT == 0) ? ST_RD_PRE : ST_RD_WAIT;
            else          state_nxt = ST_WR_PRE;
          end
        end
      end
      ST_RD_WAIT:  if (last) state_nxt = ST_RD_PRE;
      ST_RD_PRE:   if (last) state_nxt = ST_RD_BURST;
      ST_RD_BURST: if (last) state_nxt = ST_RD_POST;
      ST_RD_POST:  if (last) state_nxt = ST_IDLE;
      ST_WR_PRE:   if (last) state_nxt = ST_WR_BURST;
      ST_WR_BURST: if (last) state_nxt = ST_WR_POST;
      ST_WR_POST:  if (last) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
    if (state_nxt != state)
      cnt_nxt = state_load(state_nxt, 32'(len_nxt), RD_LAT, PRE_CYC, POST_CYC);
    else if (cnt != '0)
      cnt_nxt = cnt - 32'd1;
    else
      cnt_nxt = '0;
  end

  // State register and registered sequencing outputs decoded from next state.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      len_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      start_err <= 1'b0;
      dqs_gate  <= 1'b0;
      dqs_oe_n  <= 1'b1;
      dqs_rst_n <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      len_q     <= len_nxt;
      busy      <= (state_nxt != ST_IDLE);
      done      <= (state != ST_IDLE) && (state_nxt == ST_IDLE);
      start_err <= start_rej;
      dqs_gate  <= (state_nxt inside {ST_RD_PRE, ST_RD_BURST, ST_RD_POST});
      dqs_oe_n  <= !(state_nxt inside {ST_WR_PRE, ST_WR_BURST, ST_WR_POST});
      dqs_rst_n <= (state_nxt == ST_WR_BURST);
    end
  end

  assign in_window = (state inside {ST_RD_PRE, ST_RD_BURST, ST_RD_POST});
  assign tap_free  = !in_window && (lock == '0);

  // Tap request arbitration, deferral and saturating apply.
  always_comb begin
    if (tap_rst_req)      req_op = TAP_RST;
    else if (tap_inc_req) req_op = TAP_INC;
    else if (tap_dec_req) req_op = TAP_DEC;
    else                  req_op = TAP_NONE;

    pend_nxt = pend_op;
    apply_op = TAP_NONE;
    if (pend_op != TAP_NONE) begin
      if (tap_free) begin
        apply_op = pend_op;
        pend_nxt = TAP_NONE;
      end
    end else if (req_op != TAP_NONE) begin
      if (tap_free) apply_op = req_op;
      else          pend_nxt = req_op;
    end

    lock_nxt = (lock != '0) ? lock - LK_W'(1) : '0;
    tap_nxt  = tap_val;
    ce_nxt   = 1'b0;
    inc_nxt  = 1'b0;
    drst_nxt = 1'b0;
    sat_nxt  = 1'b0;
    unique case (apply_op)
      TAP_INC: begin
        if (tap_val == '1) begin
          sat_nxt = 1'b1;
        end else begin
          tap_nxt = tap_val + TAP_W'(1);
          ce_nxt  = 1'b1;
          inc_nxt = 1'b1;
        end
      end
      TAP_DEC: begin
        if (tap_val == '0) begin
          sat_nxt = 1'b1;
        end else begin
          tap_nxt = tap_val - TAP_W'(1);
          ce_nxt  = 1'b1;
        end
      end
      TAP_RST: begin
        tap_nxt  = '0;
        drst_nxt = 1'b1;
      end
      default: ;
    endcase
    if (apply_op != TAP_NONE) lock_nxt = LK_W'(LOCKOUT_CYC);
  end

  // Tap state and IDELAY control pulses.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      pend_op    <= TAP_NONE;
      lock       <= '0;
      tap_val    <= '0;
      dlyce_dqs  <= 1'b0;
      dlyinc_dqs <= 1'b0;
      dlyrst_dqs <= 1'b0;
      tap_sat    <= 1'b0;
    end else begin
      pend_op    <= pend_nxt;
      lock       <= lock_nxt;
      tap_val    <= tap_nxt;
      dlyce_dqs  <= ce_nxt;
      dlyinc_dqs <= inc_nxt;
      dlyrst_dqs <= drst_nxt;
      tap_sat    <= sat_nxt;
    end
  end

endmodule

// File: rtl/nand_phy_dqs_ctrl.sv
// NUM_CH independent DQS channel controllers with packed tap readback.
module nand_phy_dqs_ctrl
  import nand_phy_pkg::*;
#(
  parameter int unsigned NUM_CH   = 1,
  parameter int unsigned TAP_W    = 5,
  parameter int unsigned BURST_W  = 8,
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned PRE_CYC  = 1,
  parameter int unsigned POST_CYC = 1
) (
  input  logic                      clk0,
  input  logic                      rst0_n,
  input  logic [NUM_CH-1:0]         rd_start,
  input  logic [NUM_CH-1:0]         wr_start,
  input  logic [BURST_W-1:0]        burst_len,
  output logic [NUM_CH-1:0]         busy,
  output logic [NUM_CH-1:0]         done,
  output logic [NUM_CH-1:0]         start_err,
  output logic [NUM_CH-1:0]         dqs_gate,
  output logic [NUM_CH-1:0]         dqs_oe_n,
  output logic [NUM_CH-1:0]         dqs_rst_n,
  input  logic [NUM_CH-1:0]         tap_inc_req,
  input  logic [NUM_CH-1:0]         tap_dec_req,
  input  logic [NUM_CH-1:0]         tap_rst_req,
  output logic [NUM_CH-1:0]         dlyce_dqs,
  output logic [NUM_CH-1:0]         dlyinc_dqs,
  output logic [NUM_CH-1:0]         dlyrst_dqs,
  output logic [NUM_CH*TAP_W-1:0]   tap_val,
  output logic [NUM_CH-1:0]         tap_sat
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    nand_dqs_ch_ctrl #(
      .TAP_W   (TAP_W),
      .BURST_W (BURST_W),
      .RD_LAT  (RD_LAT),
      .PRE_CYC (PRE_CYC),
      .POST_CYC(POST_CYC)
    ) u_ch (
      .clk0       (clk0),
      .rst0_n     (rst0_n),
      .rd_start   (rd_start[i]),
      .wr_start   (wr_start[i]),
      .burst_len  (burst_len),
      .busy       (busy[i]),
      .done       (done[i]),
      .start_err  (start_err[i]),
      .dqs_gate   (dqs_gate[i]),
      .dqs_oe_n   (dqs_oe_n[i]),
      .dqs_rst_n  (dqs_rst_n[i]),
      .tap_inc_req(tap_inc_req[i]),
      .tap_dec_req(tap_dec_req[i]),
      .tap_rst_req(tap_rst_req[i]),
      .dlyce_dqs  (dlyce_dqs[i]),
      .dlyinc_dqs (dlyinc_dqs[i]),
      .dlyrst_dqs (dlyrst_dqs[i]),
      .tap_val    (tap_val[i*TAP_W +: TAP_W]),
      .tap_sat    (tap_sat[i])
    );
  end

endmodule

// File: tb/tb_nand_phy_dqs_ctrl.sv
// Bench for nand_phy_dqs_ctrl: cycle-indexed expected waveforms and
// per-channel event queues built from burst timing arithmetic.
module tb_nand_phy_dqs_ctrl;

  localparam int NCH = 2, TAP_W = 5, RD_LAT = 2, PRE = 1, POST = 1;
  localparam int H = 3000, TAP_MAX = (1 << TAP_W) - 1;
  localparam int K_DONE = 0, K_SERR = 1, K_INC = 2, K_DEC = 3, K_RST = 4, K_SAT = 5, NK = 6;

  logic clk = 1'b0;
  logic rst0_n = 1'b0;
  logic [NCH-1:0] rd_start = '0, wr_start = '0;
  logic [NCH-1:0] tap_inc_req = '0, tap_dec_req = '0, tap_rst_req = '0;
  logic [7:0] burst_len = '0;
  logic [NCH-1:0] busy, done, start_err, dqs_gate, dqs_oe_n, dqs_rst_n;
  logic [NCH-1:0] dlyce_dqs, dlyinc_dqs, dlyrst_dqs, tap_sat;
  logic [NCH*TAP_W-1:0] tap_val;

  nand_phy_dqs_ctrl #(.NUM_CH(NCH), .TAP_W(TAP_W), .BURST_W(8),
                      .RD_LAT(RD_LAT), .PRE_CYC(PRE), .POST_CYC(POST)) dut (
    .clk0(clk), .rst0_n(rst0_n), .rd_start(rd_start), .wr_start(wr_start),
    .burst_len(burst_len), .busy(busy), .done(done), .start_err(start_err),
    .dqs_gate(dqs_gate), .dqs_oe_n(dqs_oe_n), .dqs_rst_n(dqs_rst_n),
    .tap_inc_req(tap_inc_req), .tap_dec_req(tap_dec_req), .tap_rst_req(tap_rst_req),
    .dlyce_dqs(dlyce_dqs), .dlyinc_dqs(dlyinc_dqs), .dlyrst_dqs(dlyrst_dqs),
    .tap_val(tap_val), .tap_sat(tap_sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;

  // expected per-cycle levels
  bit e_busy [NCH][H];
  bit e_gate [NCH][H];
  bit e_oen  [NCH][H];
  bit e_rstn [NCH][H];
  int e_tap  [NCH][H];
  // expected pulse cycles per channel and kind
  int evq [NCH][NK][$];

  // model state
  int endc [NCH];
  int lockfree [NCH];
  int tap_m [NCH];
  int pend [NCH];

  task automatic chk(string nm, int ch, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s ch%0d cyc=%0d got=%0d exp=%0d", nm, ch, cyc, act, exp);
    end
  endtask

  function automatic string knm(int k);
    case (k)
      K_DONE: return "done";
      K_SERR: return "start_err";
      K_INC:  return "dly_inc";
      K_DEC:  return "dly_dec";
      K_RST:  return "dlyrst";
      default: return "tap_sat";
    endcase
  endfunction

  function automatic bit ev_obs(int ch, int k);
    case (k)
      K_DONE: return done[ch];
      K_SERR: return start_err[ch];
      K_INC:  return dlyce_dqs[ch] & dlyinc_dqs[ch];
      K_DEC:  return dlyce_dqs[ch] & ~dlyinc_dqs[ch];
      K_RST:  return dlyrst_dqs[ch];
      default: return tap_sat[ch];
    endcase
  endfunction

  task automatic push_ev(int ch, int k, int c);
    evq[ch][k].push_back(c);
  endtask

  // A start issued in cycle c: burst occupies cycles c+1..c+L, done at c+L+1.
  task automatic model_start(int ch, int c, bit rd, bit wr, int len);
    int l;
    if (!(rd || wr) || c <= endc[ch]) return;
    if (len == 0) begin
      push_ev(ch, K_SERR, c + 1);
      return;
    end
    if (rd) begin
      l = RD_LAT + PRE + len + POST;
      for (int k = 1; k <= l; k++) begin
        e_busy[ch][c+k] = 1'b1;
        if (k > RD_LAT) e_gate[ch][c+k] = 1'b1;
      end
    end else begin
      l = PRE + len + POST;
      for (int k = 1; k <= l; k++) begin
        e_busy[ch][c+k] = 1'b1;
        e_oen[ch][c+k]  = 1'b0;
        if (k > PRE && k <= PRE + len) e_rstn[ch][c+k] = 1'b1;
      end
    end
    push_ev(ch, K_DONE, c + l + 1);
    endc[ch] = c + l;
  endtask

  // req: 0 none, 1 inc, 2 dec, 3 rst
  task automatic model_tap(int ch, int c, int req);
    bit free;
    int op;
    free = !e_gate[ch][c] && (c >= lockfree[ch]);
    op = 0;
    if (pend[ch] != 0) begin
      if (free) begin
        op = pend[ch];
        pend[ch] = 0;
      end
    end else if (req != 0) begin
      if (free) op = req;
      else      pend[ch] = req;
    end
    if (op == 0) return;
    case (op)
      3: begin tap_m[ch] = 0; push_ev(ch, K_RST, c + 1); end
      1: if (tap_m[ch] == TAP_MAX) push_ev(ch, K_SAT, c + 1);
         else begin tap_m[ch]++; push_ev(ch, K_INC, c + 1); end
      default: if (tap_m[ch] == 0) push_ev(ch, K_SAT, c + 1);
         else begin tap_m[ch]--; push_ev(ch, K_DEC, c + 1); end
    endcase
    for (int k = c + 1; k < H; k++) e_tap[ch][k] = tap_m[ch];
    lockfree[ch] = c + 3;
  endtask

  task automatic model_reset(int from);
    for (int ch = 0; ch < NCH; ch++) begin
      endc[ch] = -1; lockfree[ch] = 0; tap_m[ch] = 0; pend[ch] = 0;
      for (int k = 0; k < NK; k++) evq[ch][k].delete();
      for (int k = from; k < H; k++) begin
        e_busy[ch][k] = 1'b0; e_gate[ch][k] = 1'b0; e_oen[ch][k] = 1'b1;
        e_rstn[ch][k] = 1'b0; e_tap[ch][k] = 0;
      end
    end
  endtask

  task automatic step(logic [1:0] rd, logic [1:0] wr, int len,
                      logic [1:0] inc, logic [1:0] dec, logic [1:0] rs);
    @(negedge clk);
    rd_start = rd; wr_start = wr; burst_len = 8'(len);
    tap_inc_req = inc; tap_dec_req = dec; tap_rst_req = rs;
    for (int ch = 0; ch < NCH; ch++) begin
      int req;
      req = rs[ch] ? 3 : inc[ch] ? 1 : dec[ch] ? 2 : 0;
      model_start(ch, cyc, rd[ch], wr[ch], len);
      model_tap(ch, cyc, req);
    end
    @(posedge clk);
  endtask

  task automatic idle(int n);
    repeat (n) step(2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00);
  endtask

  task automatic rand_cycles(int n);
    logic [1:0] rd, wr, inc, dec, rs;
    repeat (n) begin
      for (int ch = 0; ch < NCH; ch++) begin
        rd[ch]  = ($urandom % 10) == 0;
        wr[ch]  = ($urandom % 10) == 0;
        inc[ch] = ($urandom % 5) == 0;
        dec[ch] = ($urandom % 5) == 0;
        rs[ch]  = ($urandom % 30) == 0;
      end
      step(rd, wr, int'($urandom_range(0, 9)), inc, dec, rs);
    end
  endtask

  // Monitor: compare levels every cycle and pop expected pulses as they come due.
  always @(negedge clk) begin
    if (rst0_n && cyc < H) begin
      for (int ch = 0; ch < NCH; ch++) begin
        chk("busy",      ch, int'(busy[ch]),      int'(e_busy[ch][cyc]));
        chk("dqs_gate",  ch, int'(dqs_gate[ch]),  int'(e_gate[ch][cyc]));
        chk("dqs_oe_n",  ch, int'(dqs_oe_n[ch]),  int'(e_oen[ch][cyc]));
        chk("dqs_rst_n", ch, int'(dqs_rst_n[ch]), int'(e_rstn[ch][cyc]));
        chk("tap_val",   ch, int'(tap_val[ch*TAP_W +: TAP_W]), e_tap[ch][cyc]);
        for (int k = 0; k < NK; k++) begin
          bit due;
          due = (evq[ch][k].size() > 0) && (evq[ch][k][0] == cyc);
          if (due) void'(evq[ch][k].pop_front());
          chk(knm(k), ch, int'(ev_obs(ch, k)), int'(due));
        end
      end
    end
  end

  initial begin
    model_reset(0);
    #22 rst0_n = 1'b1;
    idle(3);
    // read window, burst_len 4
    step(2'b01, 2'b00, 4, 0, 0, 0); idle(12);
    // write window, burst_len 4
    step(2'b00, 2'b01, 4, 0, 0, 0); idle(10);
    // read and write together, then write during read
    step(2'b01, 2'b01, 3, 0, 0, 0); idle(2);
    step(2'b00, 2'b01, 5, 0, 0, 0); idle(12);
    // zero-length starts
    step(2'b01, 2'b00, 0, 0, 0, 0); idle(3);
    step(2'b00, 2'b10, 0, 0, 0, 0); idle(3);
    // tap saturation on ch0
    repeat (32) begin step(0, 0, 0, 2'b01, 0, 0); idle(2); end
    step(0, 0, 0, 0, 0, 2'b01); idle(2);
    step(0, 0, 0, 0, 2'b01, 0); idle(3);
    // deferred tap request during read window
    step(2'b01, 2'b00, 6, 0, 0, 0); idle(4);
    step(0, 0, 0, 2'b01, 0, 0); idle(1);
    step(0, 0, 0, 2'b01, 0, 0); idle(10);
    // randomized traffic on both channels
    rand_cycles(1200);
    for (int i = 0; i < 400 && (cyc <= endc[0] + 1 || cyc <= endc[1] + 1); i++) idle(1);
    idle(3);
    // async reset in the middle of a ch1 write burst
    step(2'b00, 2'b10, 10, 0, 0, 0); idle(3);
    @(negedge clk);
    #2 rst0_n = 1'b0;
    #1;
    chk("rst_busy",      1, int'(busy),       0);
    chk("rst_done",      1, int'(done),       0);
    chk("rst_start_err", 1, int'(start_err),  0);
    chk("rst_gate",      1, int'(dqs_gate),   0);
    chk("rst_oe_n",      1, int'(dqs_oe_n),   3);
    chk("rst_rst_n",     1, int'(dqs_rst_n),  0);
    chk("rst_dly",       1, int'({dlyce_dqs, dlyinc_dqs, dlyrst_dqs, tap_sat}), 0);
    chk("rst_tap_val",   1, int'(tap_val),    0);
    model_reset(cyc);
    @(negedge clk);
    @(negedge clk);
    #3 rst0_n = 1'b1;
    step(2'b01, 2'b00, 5, 0, 0, 0); idle(15);
    rand_cycles(200);
    idle(30);
    for (int ch = 0; ch < NCH; ch++)
      for (int k = 0; k < NK; k++)
        chk({knm(k), "_left"}, ch, evq[ch][k].size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nand_phy_dqs_ctrl.md
Name: nand_phy_dqs_ctrl

Overview:
- Per-channel DQS sequencing controller for NUM_CH NAND DQS groups. Sits between the NAND PHY command layer and the per-pin DQS IOB instances.
- Read side: generates a DQS gate window, so an undriven DQS line (no board pull-up/down) is never seen as a capture edge.
- Write side: generates dqs_oe_n and dqs_rst_n preamble/burst/postamble sequencing.
- Owns each channel's IDELAY tap bookkeeping (saturating count; dlyce/dlyinc/dlyrst pulses).

Parameters:
- NUM_CH, 1: number of DQS groups/channels.
- TAP_W, 5: IDELAY tap counter width (max tap 2^TAP_W-1 = 31).
- BURST_W, 8: width of burst_len (DQS cycles per burst).
- RD_LAT, 2: cycles from rd_start acceptance to the first gate cycle (0 allowed).
- PRE_CYC, 1: preamble cycles (read and write), >=1.
- POST_CYC, 1: postamble cycles (read and write), >=1.

Ports:
- clk0  in  1  controller clock.
- rst0_n  in  1  asynchronous active-low reset.
- rd_start  in  NUM_CH  per-channel read burst request, one-cycle pulse.
- wr_start  in  NUM_CH  per-channel write burst request, one-cycle pulse.
- burst_len  in  BURST_W  DQS cycles of burst, shared, sampled on an accepted start.
- busy  out  NUM_CH  channel FSM not IDLE.
- done  out  NUM_CH  one-cycle pulse in the first IDLE cycle after a burst.
- start_err  out  NUM_CH  one-cycle pulse: start rejected because burst_len==0.
- dqs_gate  out  NUM_CH  read DQS capture enable.
- dqs_oe_n  out  NUM_CH  DQS output enable, active low.
- dqs_rst_n  out  NUM_CH  DQS toggle enable (low = hold DQS low).
- tap_inc_req / tap_dec_req / tap_rst_req  in  NUM_CH each  tap adjust request pulses.
- dlyce_dqs / dlyinc_dqs / dlyrst_dqs  out  NUM_CH each  to IDELAY CE/INC/REGRST.
- tap_val  out  NUM_CH*TAP_W  current tap per channel; channel i at [i*TAP_W +: TAP_W].
- tap_sat  out  NUM_CH  one-cycle pulse: inc at max or dec at 0 refused.

Behaviour:
- Reset values: busy=0, done=0, start_err=0, dqs_gate=0, dqs_oe_n=1, dqs_rst_n=0, all dly*=0, tap_val=0, pending=0.
- Reset asserted mid-burst forces IDLE and these values asynchronously. No done pulse follows.
- All outputs are registered. Channels are fully independent.
- States: IDLE, RD_WAIT, RD_PRE, RD_BURST, RD_POST, WR_PRE, WR_BURST, WR_POST. A single down-counter is loaded at each state entry.
- IDLE + rd_start (burst_len!=0): go to RD_WAIT for RD_LAT cycles, or straight to RD_PRE if RD_LAT=0. Then RD_PRE for PRE_CYC, RD_BURST for burst_len, RD_POST for POST_CYC, then IDLE.
- dqs_gate=1 exactly in the RD_PRE, RD_BURST and RD_POST states.
- IDLE + wr_start: WR_PRE (oe_n=0, rst_n=0) for PRE_CYC, then WR_BURST (oe_n=0, rst_n=1) for burst_len, then WR_POST (oe_n=0, rst_n=0) for POST_CYC, then IDLE.
- rd_start and wr_start together in IDLE: read wins, write is dropped.
- Starts while busy are ignored (no error).
- burst_len==0: the start is rejected, start_err pulses next cycle, state stays IDLE.
- done pulses for one cycle on the cycle the FSM is back in IDLE.
- Tap request priority: rst > inc > dec.
- Tap requests arriving in RD_PRE..RD_POST, or during lockout, are latched into a one-deep pending slot. Further requests while the slot is full are dropped.
- A request is applied in the first cycle outside the gate window with no lockout.
- Apply inc: dlyce=1 and dlyinc=1 for one cycle; tap_val+1 on the same edge.
- Apply dec: dlyce=1 and dlyinc=0 for one cycle; tap_val-1 on the same edge.
- Apply rst: dlyrst=1 for one cycle; tap_val=0.
- Inc at max or dec at 0: no dlyce; tap_sat pulses instead. The counter never wraps.
- Each applied request (including a refused one) starts a 2-cycle lockout.

Decomposition:
- Shared package nand_phy_pkg holds:
  - the state enum (3-bit encoding);
  - the lockout constant (2);
  - a helper function for the per-state counter load.
- Natural sub-module: nand_dqs_ch_ctrl, a single-channel FSM plus tap logic. The top instantiates NUM_CH copies via generate and packs tap_val.

Test Plan:
- Read window: RD_LAT=2, PRE=POST=1, burst_len=4, rd_start at cycle 0 -> busy cycles 1-8, dqs_gate cycles 3-8 (6 cycles), done at cycle 9, dqs_oe_n stays 1.
- Write window: burst_len=4, wr_start at cycle 0 -> oe_n=0 cycles 1-6, rst_n=0@1, rst_n=1@2-5, rst_n=0@6, done at cycle 7, dqs_gate stays 0.
- Collisions: rd_start+wr_start same cycle -> read sequence only. wr_start during read -> ignored. burst_len=0 -> start_err pulse, busy stays 0.
- Tap saturation: 32 inc requests spaced 3 cycles from 0 -> 31 dlyce pulses, tap_val=31, last request gives a tap_sat pulse. A dec at 0 after tap_rst -> tap_sat pulse, no dlyce.
- Deferred tap: inc request during RD_BURST, second request also during the window -> single dlyce one cycle after RD_POST ends, second request dropped.
- Async reset: rst0_n low mid-WR_BURST on ch1 of NUM_CH=2 -> all outputs at reset values immediately (no clock edge needed), no done pulse. After reset release, ch0 rd_start runs normally.
